instruction_encode: RTL and testbench
=====================================

INSTRUCTION_ENCODE -- requirements
Module: instruction_encode

Interface
REQ-001 Parameter DEPTH, default 4, number of encoded-instruction buffer entries; power of two, at least 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  encode request present.
REQ-005 req_ready  out  1  block accepts request this cycle.
REQ-006 req_kind  in  2  instruction kind: 00 ALU (R-type), 01 LOAD (LW), 10 STORE (SW), 11 reserved.
REQ-007 req_rs / req_rt / req_rd  in  5 each  register fields; req_rd used only by ALU.
REQ-008 req_funct  in  6  R-type function field; ALU only.
REQ-009 req_imm  in  16  immediate; LOAD/STORE only.
REQ-010 instr_valid  out  1  encoded word available.
REQ-011 instr_ready  in  1  downstream consumes word this cycle.
REQ-012 instr  out  32  encoded MIPS instruction word at buffer head.
REQ-013 err_illegal  out  1  one-cycle pulse on accepted reserved-kind request.
REQ-014 issue_count  out  16  count of completed instr handshakes.

Function
REQ-015 Request handshake SHALL complete when req_valid && req_ready; instr handshake when instr_valid && instr_ready.
REQ-016 ALU encoding SHALL be {6'b000000, rs, rt, rd, 5'b00000, funct}.
REQ-017 LOAD encoding SHALL be {6'b100011, rs, rt, imm}; STORE SHALL be {6'b101011, rs, rt, imm}.
REQ-018 Fields unused by the kind SHALL be ignored and SHALL NOT affect instr.
REQ-019 Accepted legal requests SHALL be written in order into a DEPTH-entry FIFO; instr SHALL present the head entry.
REQ-020 Latency SHALL be exactly one cycle: word accepted at edge N is visible with instr_valid=1 after edge N; no combinational req-to-instr path.
REQ-021 req_ready SHALL equal !full && !rst; a push when full is never accepted, even with a simultaneous pop.
REQ-022 Simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged and preserve order.
REQ-023 instr_valid SHALL equal !empty; when empty instr SHALL be 32'h00000000.
REQ-024 instr SHALL remain stable while instr_valid && !instr_ready.
REQ-025 Reserved kind (11) SHALL complete the handshake, NOT be written to the FIFO, and pulse err_illegal for the following cycle only.
REQ-026 issue_count SHALL increment by 1 per instr handshake and wrap from 16'hFFFF to 16'h0000.
REQ-027 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy tracked with DEPTH+1 distinct values.

Reset
REQ-028 While rst=1 at an edge: FIFO emptied, pointers 0, instr_valid=0, instr=0, err_illegal=0, issue_count=0, req_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words with no instr handshake afterward; req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro INSTR_ENCODE_STATS_EN: when defined, issue_count behaves per REQ-026; when undefined, issue_count SHALL be tied to 16'h0000 and the counter SHALL NOT be built.

Structure
REQ-031 Shared package mips_pkg SHALL hold opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011 and the 2-bit kind enum.
REQ-032 Buffering SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH); encoding logic stays in instruction_encode.

Verification
REQ-033 ALU rs=1 rt=2 rd=3 funct=6'h20 pushed, instr_ready=1 -> next cycle instr_valid=1, instr=32'h00221820, then empty.
REQ-034 LOAD rs=2 rt=3 imm=16'h0010, STORE rs=29 rt=31 imm=16'hFFFC back-to-back -> 32'h8C430010 then 32'hAFBFFFFC in order.
REQ-035 instr_ready=0, push 4 legal requests (DEPTH=4) -> req_ready=0 on 5th; hold instr_ready=0 -> instr stable; release -> 4 words drain in order.
REQ-036 req_kind=11 accepted -> err_illegal=1 for one cycle, instr_valid stays 0, issue_count unchanged.
REQ-037 FIFO holding 3 words, rst=1 for one cycle -> instr_valid=0, issue_count=0, req_ready=1 the next cycle.
REQ-038 With INSTR_ENCODE_STATS_EN, preload issue_count to 16'hFFFF via 65535 handshakes, one more -> 16'h0000; without macro, issue_count=0 throughout.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the request-kind enum for the encoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'b00,
    KIND_LOAD  = 2'b01,
    KIND_STORE = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two DEPTH, synchronous active-high reset.
// rdata reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_encode.sv
// Encodes ALU / LW / SW requests into 32-bit MIPS words and buffers them
// in a DEPTH-entry FIFO. Reserved-kind requests are accepted, dropped, and
// flagged on err_illegal for one cycle.
// Optional macro INSTR_ENCODE_STATS_EN builds the issue_count handshake
// counter; without it issue_count is constant zero.
module instruction_encode
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [5:0]  req_funct,
  input  logic [15:0] req_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        err_illegal,
  output logic [15:0] issue_count
);

  kind_e       kind;
  logic        req_hs;
  logic        instr_hs;
  logic        legal;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] encoded;

  assign kind        = kind_e'(req_kind);
  assign legal       = (kind != KIND_RSVD);
  assign req_ready   = !fifo_full && !rst;
  assign req_hs      = req_valid && req_ready;
  assign instr_valid = !fifo_empty;
  assign instr_hs    = instr_valid && instr_ready;

  // Build the instruction word; fields the kind does not use never reach it.
  always_comb begin
    encoded = '0;
    case (kind)
      KIND_ALU:   encoded = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, req_funct};
      KIND_LOAD:  encoded = {OP_LW, req_rs, req_rt, req_imm};
      KIND_STORE: encoded = {OP_SW, req_rs, req_rt, req_imm};
      default:    encoded = '0;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_hs && legal),
    .pop   (instr_hs),
    .wdata (encoded),
    .rdata (instr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One-cycle error pulse following an accepted reserved-kind request.
  always_ff @(posedge clk) begin
    if (rst) err_illegal <= 1'b0;
    else     err_illegal <= req_hs && !legal;
  end

`ifdef INSTR_ENCODE_STATS_EN
  // Free-running count of completed output handshakes, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)           issue_count <= '0;
    else if (instr_hs) issue_count <= issue_count + 16'd1;
  end
`else
  assign issue_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_encode.sv
// Randomized scoreboard bench for instruction_encode (DEPTH = 4).
module tb_instruction_encode;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'b00;
  logic [4:0]  req_rs = '0;
  logic [4:0]  req_rt = '0;
  logic [4:0]  req_rd = '0;
  logic [5:0]  req_funct = '0;
  logic [15:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic        err_illegal;
  logic [15:0] issue_count;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];
  logic        exp_err = 1'b0;
  logic [15:0] exp_cnt = 16'h0000;
  bit          mon_en  = 1'b0;

  instruction_encode #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_funct   (req_funct),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .err_illegal (err_illegal),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  // Reference encoder: opcode/field placement by positional arithmetic.
  function automatic logic [31:0] model(input logic [1:0] k, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] funct, input logic [15:0] imm);
    longint unsigned w;
    longint unsigned base;
    base = longint'(rs) * (64'd1 << 21) + longint'(rt) * (64'd1 << 16);
    case (k)
      2'd0:    w = base + longint'(rd) * (64'd1 << 11) + longint'(funct);
      2'd1:    w = 64'd35 * (64'd1 << 26) + base + longint'(imm);
      2'd2:    w = 64'd43 * (64'd1 << 26) + base + longint'(imm);
      default: w = 64'd0;
    endcase
    return w[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares every output against the model each cycle, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic [31:0] head;
        head = (sb.size() != 0) ? sb[0] : 32'h0;
        check("req_ready",   32'(req_ready),   32'(!rst && (sb.size() < DEPTH)));
        check("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
        check("instr",       instr,            head);
        check("err_illegal", 32'(err_illegal), 32'(exp_err));
        check("issue_count", 32'(issue_count), 32'(exp_cnt));
        if (rst) begin
          sb.delete();
          exp_cnt = 16'h0000;
        end else if (sb.size() != 0 && instr_ready) begin
          void'(sb.pop_front());
`ifdef INSTR_ENCODE_STATS_EN
          exp_cnt = exp_cnt + 16'd1;
`endif
        end
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit v, input logic [1:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
                      input logic [15:0] imm, input bit ir, input bit r,
                      input logic [31:0] exp);
    bit hs;
    req_valid = v; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
    req_funct = funct; req_imm = imm; instr_ready = ir; rst = r;
    @(negedge clk);
    hs = v && req_ready;
    @(posedge clk);
    #1;
    if (hs && k != 2'b11) sb.push_back(exp);
    exp_err = hs && (k == 2'b11);
  endtask

  task automatic idle(input bit ir, input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           6'($urandom), 16'($urandom), ir, 1'b0, 32'h0);
  endtask

  task automatic rand_step(input bit v, input bit legal_only, input bit ir);
    logic [1:0]  k;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] im;
    k  = legal_only ? 2'($urandom_range(0, 2)) : 2'($urandom);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    fn = 6'($urandom); im = 16'($urandom);
    step(v, k, rs, rt, rd, fn, im, ir, 1'b0, model(k, rs, rt, rd, fn, im));
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0, 1'b1, 32'h0);

    // Single ALU word, consumed on arrival.
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 6'h20, 16'hBEEF, 1'b1, 1'b0, 32'h00221820);
    idle(1'b1, 2);

    // LOAD then STORE back-to-back; rd/funct are junk and must not leak in.
    step(1'b1, 2'b01, 5'd2, 5'd3, 5'd17, 6'h3F, 16'h0010, 1'b0, 1'b0, 32'h8C430010);
    step(1'b1, 2'b10, 5'd29, 5'd31, 5'd9, 6'h15, 16'hFFFC, 1'b0, 1'b0, 32'hAFBFFFFC);
    idle(1'b1, 3);

    // Fill to DEPTH with the consumer stalled, try one more, hold, then drain.
    for (int i = 0; i < DEPTH + 1; i++) rand_step(1'b1, 1'b1, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, DEPTH + 2);

    // Reserved kind: accepted, dropped, one-cycle error pulse.
    rand_step(1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b11, 5'd4, 5'd5, 5'd6, 6'h07, 16'h1234, 1'b1, 1'b0, 32'h0);
    idle(1'b1, 2);

    // Reset with three words buffered.
    for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b1, 1'b0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b1, 1'b1, 32'h0);
    rand_step(1'b1, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Random traffic including reserved kinds and back-pressure.
    for (int i = 0; i < 400; i++)
      rand_step(($urandom % 4) != 0, 1'b0, ($urandom % 3) != 0);
    idle(1'b1, DEPTH + 2);

`ifdef INSTR_ENCODE_STATS_EN
    // Steady push+pop to carry issue_count through its 16-bit wrap.
    for (int i = 0; i < 65540; i++)
      step(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 1'b1, 1'b0, 32'h00221820);
    idle(1'b1, 3);
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
